md_sched: RTL

- Multiply/divide sequencer for the pipelined MIPS datapath. Sits beside the ALU in the E stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Raises a stall request to the hazard logic while any instruction in D needs the unit and the unit is occupied.

---
 rtl/md_sched_if.sv | 22 ++
 rtl/md_sched.sv | 101 ++++++++++
 2 files changed

// File: rtl/md_sched_if.sv
// E-stage <-> multiply/divide sequencer bundle: op and operands in, HI/LO and status out.
// The master drives the op and operands and reads the results; the slave is the sequencer.
interface md_sched_if;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_use_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  modport master (
    output md_op, rs_val, rt_val, d_use_md,
    input  hi, lo, busy, md_stall
  );

  modport slave (
    input  md_op, rs_val, rt_val, d_use_md,
    output hi, lo, busy, md_stall
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer that owns HI/LO. The result is computed at issue and held in
// pending registers, then committed when the fixed-latency busy counter expires.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave md
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  logic busy, start, is_mul, is_div, sgn_mul, sgn_div, div_zero;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] divisor, dvd_mag, dvs_mag, quo_mag, rem_mag, quo, rem;

  assign busy     = (cnt_q != '0);
  assign is_mul   = (md.md_op == OpMult) || (md.md_op == OpMultu);
  assign is_div   = (md.md_op == OpDiv) || (md.md_op == OpDivu);
  assign start    = (is_mul || is_div) && !busy;
  assign sgn_mul  = (md.md_op == OpMult);
  assign sgn_div  = (md.md_op == OpDiv);
  assign div_zero = (md.rt_val == 32'd0);

  // One 64x64 multiplier serves both: the low 64 bits are exact once operands are extended.
  assign mul_a = {{32{sgn_mul & md.rs_val[31]}}, md.rs_val};
  assign mul_b = {{32{sgn_mul & md.rt_val[31]}}, md.rt_val};
  assign prod  = mul_a * mul_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
  assign divisor = div_zero ? 32'd1 : md.rt_val;
  assign dvd_mag = (sgn_div && md.rs_val[31]) ? -md.rs_val : md.rs_val;
  assign dvs_mag = (sgn_div && divisor[31]) ? -divisor : divisor;
  assign quo_mag = dvd_mag / dvs_mag;
  assign rem_mag = dvd_mag % dvs_mag;
  assign quo     = (sgn_div && (md.rs_val[31] ^ md.rt_val[31])) ? -quo_mag : quo_mag;
  assign rem     = (sgn_div && md.rs_val[31]) ? -rem_mag : rem_mag;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (start) begin
      cnt_d     = is_div ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
      pend_hi_d = is_div ? rem : prod[63:32];
      pend_lo_d = is_div ? quo : prod[31:0];
      pend_wr_d = !(is_div && div_zero);
    end else if (busy) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (md.md_op == OpMthi) begin
      hi_d = md.rs_val;
    end else if (md.md_op == OpMtlo) begin
      lo_d = md.rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.busy     = busy;
  assign md.md_stall = md.d_use_md & (busy | start);

endmodule
